// File: rtl/seq_pkg.sv
// Shared definitions for the microprogram sequencer: default widths, FSM
// state encoding and the microaddress reset vector.
package seq_pkg;

   localparam int SEQ_MBR_W       = 8;
   localparam int SEQ_ADDR_W      = 9;
   localparam int SEQ_STACK_DEPTH = 4;
   localparam int MPC_RESET       = 0;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_HALT  = 2'd3
   } seq_state_e;

endpackage : seq_pkg

// File: rtl/micro_sequencer_return_stack.sv
// LIFO return-address stack with occupancy count and sticky overflow and
// underflow flags. A pop and a push in the same cycle resolve as a pop only.
module return_stack #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 9
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic [DATA_W-1:0]         i_data,
   output logic [DATA_W-1:0]         o_top,
   output logic                      o_empty,
   output logic [$clog2(DEPTH):0]    o_level,
   output logic                      o_ovf,
   output logic                      o_unf
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   generate
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("return_stack: DEPTH must be a power of two and at least 2");
      end
   endgenerate

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [LW-1:0]     r_level;
   logic              r_ovf;
   logic              r_unf;

   logic              w_full;
   logic              w_empty;
   logic              w_do_push;
   logic              w_do_pop;
   logic [LW-1:0]     w_level_m1;

   assign w_full     = (r_level == LW'(DEPTH));
   assign w_empty    = (r_level == '0);
   assign w_do_pop   = i_pop && !w_empty;
   assign w_do_push  = i_push && !i_pop && !w_full;
   assign w_level_m1 = r_level - LW'(1);

   // Top entry sits one below the level; when empty the value is unused.
   assign o_top   = r_mem[w_level_m1[PW-1:0]];
   assign o_empty = w_empty;
   assign o_level = r_level;
   assign o_ovf   = r_ovf;
   assign o_unf   = r_unf;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_level <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         if (w_do_pop) begin
            r_level <= w_level_m1;
         end else if (w_do_push) begin
            r_level <= r_level + LW'(1);
         end
         if (i_push && !i_pop && w_full) begin
            r_ovf <= 1'b1;
         end
         if (i_pop && w_empty) begin
            r_unf <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_level[PW-1:0]] <= i_data;
      end
   end

endmodule : return_stack

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registers the next microaddress from NEXT_ADDRESS,
// the jump condition, MBR dispatch and a call/return stack; stalls on mem wait.
//
//   state | meaning
//   BOOT  | first cycle after reset, control store idle, mpc held at 0
//   RUN   | control store read, mpc advances every edge
//   STALL | memory busy, mpc held, inputs ignored
//   HALT  | frozen until reset
module micro_sequencer
   import seq_pkg::*;
#(
   parameter int MBR_W       = SEQ_MBR_W,
   parameter int ADDR_W      = SEQ_ADDR_W,
   parameter int STACK_DEPTH = SEQ_STACK_DEPTH
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [ADDR_W-1:0]             i_next_addr,
   input  logic                          i_j_high,
   input  logic                          i_jmpc,
   input  logic [MBR_W-1:0]              i_mbr,
   input  logic                          i_call,
   input  logic                          i_ret,
   input  logic                          i_halt_req,
   input  logic                          i_mem_wait,
   output logic [ADDR_W-1:0]             o_mpc,
   output logic                          o_cs_rd,
   output logic                          o_halted,
   output logic                          o_stack_ovf,
   output logic                          o_stack_unf,
   output logic [$clog2(STACK_DEPTH):0]  o_stack_level
);

   generate
      if (ADDR_W != MBR_W + 1) begin : g_bad_width
         $error("micro_sequencer: ADDR_W must equal MBR_W+1");
      end
   endgenerate

   seq_state_e        r_state;
   seq_state_e        w_state_nxt;
   logic [ADDR_W-1:0] r_mpc;
   logic [ADDR_W-1:0] w_mpc_nxt;
   logic [ADDR_W-1:0] w_normal;
   logic [ADDR_W-1:0] w_ret_addr;
   logic [ADDR_W-1:0] w_top;
   logic [MBR_W-1:0]  w_low;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;

   // MIC-1 rule: j_high forces the MSB and jmpc ORs the opcode into the low byte.
   assign w_low      = i_jmpc ? (i_next_addr[MBR_W-1:0] | i_mbr) : i_next_addr[MBR_W-1:0];
   assign w_normal   = {i_next_addr[ADDR_W-1] | i_j_high, w_low};
   assign w_ret_addr = r_mpc + ADDR_W'(1);

   return_stack #(
      .DEPTH  (STACK_DEPTH),
      .DATA_W (ADDR_W)
   ) u_return_stack (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_ret_addr),
      .o_top   (w_top),
      .o_empty (w_empty),
      .o_level (o_stack_level),
      .o_ovf   (o_stack_ovf),
      .o_unf   (o_stack_unf)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_BOOT;
         r_mpc   <= ADDR_W'(MPC_RESET);
      end else begin
         r_state <= w_state_nxt;
         r_mpc   <= w_mpc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mpc_nxt   = r_mpc;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         ST_BOOT: begin
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (i_halt_req) begin
               w_state_nxt = ST_HALT;
            end else if (i_mem_wait) begin
               w_state_nxt = ST_STALL;
            end else if (i_ret) begin
               w_pop     = 1'b1;
               w_mpc_nxt = w_empty ? ADDR_W'(MPC_RESET) : w_top;
            end else if (i_call) begin
               w_push    = 1'b1;
               w_mpc_nxt = w_normal;
            end else begin
               w_mpc_nxt = w_normal;
            end
         end
         ST_STALL: begin
            // Leaving the stall spends one edge; the held word re-sequences afterwards.
            if (i_halt_req) begin
               w_state_nxt = ST_HALT;
            end else if (!i_mem_wait) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end
         default: begin
            w_state_nxt = ST_BOOT;
         end
      endcase
   end

   assign o_mpc    = r_mpc;
   assign o_cs_rd  = (r_state == ST_RUN);
   assign o_halted = (r_state == ST_HALT);

endmodule : micro_sequencer

// File: tb/tb_micro_sequencer.sv
// Directed plus randomized bench for micro_sequencer, checked every cycle
// against a queue-based behavioural model of the sequencing rules.
module tb_micro_sequencer;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic [8:0] next_addr;
   logic       j_high;
   logic       jmpc;
   logic [7:0] mbr;
   logic       call;
   logic       ret;
   logic       halt_req;
   logic       mem_wait;
   logic [8:0] mpc;
   logic       cs_rd;
   logic       halted;
   logic       stack_ovf;
   logic       stack_unf;
   logic [2:0] stack_level;

   int n_cmp = 0;
   int n_mis = 0;

   int m_mpc;
   int m_stack[$];
   bit m_ovf, m_unf;
   bit m_boot, m_stall, m_halt;

   micro_sequencer dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_next_addr   (next_addr),
      .i_j_high      (j_high),
      .i_jmpc        (jmpc),
      .i_mbr         (mbr),
      .i_call        (call),
      .i_ret         (ret),
      .i_halt_req    (halt_req),
      .i_mem_wait    (mem_wait),
      .o_mpc         (mpc),
      .o_cs_rd       (cs_rd),
      .o_halted      (halted),
      .o_stack_ovf   (stack_ovf),
      .o_stack_unf   (stack_unf),
      .o_stack_level (stack_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      assert (got === exp) else begin
         n_mis++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int normal_addr();
      int lo, hi;
      lo = next_addr % 256;
      if (jmpc) lo = lo | int'(mbr);
      hi = ((next_addr / 256) != 0 || j_high) ? 256 : 0;
      return hi + lo;
   endfunction

   task automatic model_step();
      if (m_boot) begin
         m_boot = 0;
      end else if (m_halt) begin
         // frozen
      end else if (m_stall) begin
         if (halt_req) begin
            m_stall = 0;
            m_halt  = 1;
         end else if (!mem_wait) begin
            m_stall = 0;
         end
      end else if (halt_req) begin
         m_halt = 1;
      end else if (mem_wait) begin
         m_stall = 1;
      end else if (ret) begin
         if (m_stack.size() > 0) begin
            m_mpc = m_stack.pop_back();
         end else begin
            m_mpc = 0;
            m_unf = 1;
         end
      end else begin
         if (call) begin
            if (m_stack.size() < DEPTH) m_stack.push_back((m_mpc + 1) % 512);
            else m_ovf = 1;
         end
         m_mpc = normal_addr();
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".mpc"},   int'(mpc),         m_mpc);
      chk({tag, ".cs_rd"}, int'(cs_rd),       int'(!m_boot && !m_stall && !m_halt));
      chk({tag, ".halt"},  int'(halted),      int'(m_halt));
      chk({tag, ".ovf"},   int'(stack_ovf),   int'(m_ovf));
      chk({tag, ".unf"},   int'(stack_unf),   int'(m_unf));
      chk({tag, ".level"}, int'(stack_level), m_stack.size());
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic drive(input int na, input bit jh, input bit jm, input int mb,
                        input bit ca, input bit re, input bit hr, input bit mw);
      next_addr = 9'(na);
      j_high    = jh;
      jmpc      = jm;
      mbr       = 8'(mb);
      call      = ca;
      ret       = re;
      halt_req  = hr;
      mem_wait  = mw;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #2;
      m_mpc = 0;
      m_stack.delete();
      m_ovf = 0; m_unf = 0; m_stall = 0; m_halt = 0; m_boot = 1;
      check_all({tag, ".rst"});
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all({tag, ".boot"});
      cycle({tag, ".torun"});
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      do_reset("init");

      // Reset mid-run at 0x05A
      drive(16'h05A, 0, 0, 0, 0, 0, 0, 0);
      cycle("goto5a");
      chk("mpc5a", int'(mpc), 16'h05A);
      do_reset("midrun");
      chk("rst_mpc", int'(mpc), 0);
      drive(16'h010, 0, 0, 0, 0, 0, 0, 0);
      cycle("boot010");
      chk("mpc010", int'(mpc), 16'h010);

      // Branch and dispatch
      drive(16'h020, 1, 0, 0, 0, 0, 0, 0);
      cycle("jhigh");
      chk("jhigh_val", int'(mpc), 16'h120);
      drive(16'h100, 0, 1, 16'h36, 0, 0, 0, 0);
      cycle("jmpc");
      chk("jmpc_val", int'(mpc), 16'h136);
      drive(16'h000, 1, 1, 16'h36, 0, 0, 0, 0);
      cycle("both");
      chk("both_val", int'(mpc), 16'h136);

      // Call nesting, overflow, returns, underflow
      drive(16'h010, 0, 0, 0, 0, 0, 0, 0);
      cycle("to010");
      for (int i = 0; i < 4; i++) begin
         drive(16'h030 + 16'h20 * i, 0, 0, 0, 1, 0, 0, 0);
         cycle("call");
      end
      chk("lvl4", int'(stack_level), 4);
      drive(16'h0A0, 0, 0, 0, 1, 0, 0, 0);
      cycle("call5");
      chk("ovf5", int'(stack_ovf), 1);
      chk("br5", int'(mpc), 16'h0A0);
      for (int i = 0; i < 4; i++) begin
         drive(16'h1EE, 1, 1, 16'hFF, 0, 1, 0, 0);
         cycle("ret");
         chk("retaddr", int'(mpc), 16'h071 - 16'h20 * i);
      end
      cycle("ret5");
      chk("ret5_mpc", int'(mpc), 0);
      chk("unf5", int'(stack_unf), 1);

      // Stall with a call held during the stall
      do_reset("stall");
      drive(16'h044, 0, 0, 0, 0, 0, 0, 0);
      cycle("to044");
      drive(16'h060, 0, 0, 0, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         cycle("stall");
         chk("stall_mpc", int'(mpc), 16'h044);
         chk("stall_cs", int'(cs_rd), 0);
      end
      drive(16'h060, 0, 0, 0, 0, 0, 0, 0);
      cycle("release");
      chk("rel_mpc", int'(mpc), 16'h044);
      cycle("rerun");
      chk("rerun_mpc", int'(mpc), 16'h060);
      chk("nopush", int'(stack_level), 0);

      // Call+ret priority then halt
      do_reset("prio");
      drive(16'h080, 0, 0, 0, 1, 0, 0, 0);
      cycle("pc1");
      drive(16'h0C0, 0, 0, 0, 1, 0, 0, 0);
      cycle("pc2");
      drive(16'h1F0, 0, 0, 0, 1, 1, 0, 0);
      cycle("callret");
      chk("cr_lvl", int'(stack_level), 1);
      chk("cr_mpc", int'(mpc), 16'h081);
      drive(16'h1F0, 0, 0, 0, 0, 0, 1, 1);
      cycle("halt");
      chk("halted", int'(halted), 1);
      for (int i = 0; i < 10; i++) begin
         drive($urandom_range(0, 511), 1'($urandom), 1'($urandom), $urandom_range(0, 255),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         cycle("frozen");
         chk("frozen_mpc", int'(mpc), 16'h081);
      end
      do_reset("unhalt");

      // Wrap of the pushed return address
      drive(16'h1FF, 0, 0, 0, 0, 0, 0, 0);
      cycle("to1ff");
      drive(16'h005, 0, 0, 0, 1, 0, 0, 0);
      cycle("callwrap");
      drive(16'h005, 0, 0, 0, 0, 1, 0, 0);
      cycle("retwrap");
      chk("wrap_mpc", int'(mpc), 0);
      chk("wrap_unf", int'(stack_unf), 0);

      // Randomized traffic
      do_reset("rand");
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 511), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 255), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 79) == 0, $urandom_range(0, 4) == 0);
         cycle("rand");
         if (m_halt && ($urandom_range(0, 3) == 0)) do_reset("rand_rst");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_micro_sequencer

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer. It is the consumer of the jump-condition bit produced by the flag unit (J_out, here port j_high).
- Each cycle it computes the next microinstruction address (MPC) from the control-store NEXT_ADDRESS field, j_high, the JMPC/MBR dispatch and a small call/return stack.
- It drives the control-store read and stalls on memory wait.
- It sits between the flag unit/control store and the datapath control word register.

Parameters:
- MBR_W, 8, width of MBR dispatch byte.
- ADDR_W, 9, microaddress width. Must equal MBR_W+1; the sequencer checks this at elaboration.
- STACK_DEPTH, 4, return-stack entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- next_addr  in  ADDR_W  NEXT_ADDRESS field of current microinstruction.
- j_high  in  1  jump condition from flag unit (J_out); ORed into MPC MSB.
- jmpc  in  1  dispatch: OR MBR into low bits.
- mbr  in  MBR_W  memory buffer byte (opcode).
- call  in  1  push return address, then branch.
- ret  in  1  pop return address into MPC.
- halt_req  in  1  enter HALT.
- mem_wait  in  1  memory busy; freeze sequencing.
- mpc  out  ADDR_W  current microaddress to control store.
- cs_rd  out  1  control-store read enable.
- halted  out  1  sequencer in HALT.
- stack_ovf  out  1  sticky push-on-full flag.
- stack_unf  out  1  sticky pop-on-empty flag.
- stack_level  out  clog2(STACK_DEPTH)+1  current stack occupancy.

Behaviour:
- Reset (async, rst=1):
  - state=BOOT; mpc=0; cs_rd=0; halted=0.
  - stack_ovf=0; stack_unf=0; stack_level=0; stack contents don't-care.
  - Reset mid-operation aborts everything immediately.
- States:
  - BOOT: one cycle after rst deasserts, cs_rd=0, mpc held at 0 → RUN.
  - RUN: cs_rd=1.
    - halt_req=1 → HALT (mpc held).
    - Else mem_wait=1 → STALL (mpc held).
    - Else mpc ← next address at the rising edge.
  - STALL: cs_rd=0, mpc held.
    - halt_req → HALT.
    - mem_wait=0 → RUN. No address update on that exit edge; the held microinstruction re-executes its sequencing on the next RUN edge.
  - HALT: cs_rd=0, halted=1, mpc frozen. Leaves only via rst.
- Priority at each RUN edge: halt_req > mem_wait > ret > call > normal.
- Normal next address (registered, 1-cycle latency from inputs to mpc):
  - low[MBR_W-1:0] = jmpc ? (next_addr[MBR_W-1:0] | mbr) : next_addr[MBR_W-1:0].
  - msb = next_addr[ADDR_W-1] | j_high.
  - j_high and jmpc are both honoured simultaneously (MIC-1 rule).
- call:
  - Push mpc+1; the increment wraps mod 2^ADDR_W, so 0x1FF+1 pushes 0x000.
  - mpc ← normal next address. stack_level+1.
  - If full: no push, level unchanged, stack_ovf←1, branch still taken.
- ret:
  - mpc ← top of stack; stack_level-1. next_addr, j_high and jmpc are ignored.
  - If empty: mpc ← 0, stack_unf←1.
- call and ret together: ret wins, call ignored, no push.
- Stack is LIFO with a pointer. Level never exceeds STACK_DEPTH and never goes below 0.
- Sticky flags clear only on rst.
- Inputs are sampled only in RUN; values in BOOT, STALL and HALT are ignored.

Decomposition:
- Shared package (seq_pkg): ADDR_W/MBR_W defaults; state encoding BOOT=2'd0, RUN=2'd1, STALL=2'd2, HALT=2'd3; reset vector constant MPC_RESET=0.
- One sub-module: return_stack (push/pop/full/empty/level, overflow and underflow detection). Next-address logic and the FSM stay in micro_sequencer.

Test Plan:
- Reset and boot: assert rst mid-run at mpc=0x05A → mpc=0x000 and cs_rd=0 immediately. After deassert, one BOOT cycle, then cs_rd=1. With next_addr=0x010 → mpc=0x010 the following edge.
- Branch and dispatch: next_addr=0x020, j_high=1 → mpc=0x120. next_addr=0x100, jmpc=1, mbr=0x36 → mpc=0x136. Both with j_high=1, next_addr=0x000 → mpc=0x136.
- Call/return nesting: call ×4 from mpc=0x010,0x030,0x050,0x070 → level=4. Fifth call → stack_ovf=1, level=4, branch taken. Four rets → mpc 0x071,0x051,0x031,0x011. Fifth ret → mpc=0x000, stack_unf=1.
- Stall: mem_wait=1 for 3 cycles at mpc=0x044 → mpc stays 0x044, cs_rd=0. Release → one RUN edge later mpc=next_addr. A call asserted during the stall causes no push.
- Priority and halt: call=ret=1 with level=2 → pop occurs, level=1. halt_req=1 with mem_wait=1 → HALT, halted=1, mpc frozen for 10 cycles despite input activity. Only rst exits.
- Wrap: call at mpc=0x1FF → pushed 0x000; subsequent ret → mpc=0x000 with stack_unf still 0.
